// File: rtl/risac_lsu_pkg.sv
// risac_lsu_pkg: shared definitions for the risac load/store unit.
//   - RV32I load/store funct3 encodings
//   - LSU state enum and error-class enum
//   - helpers: request classification, lane byteenable, lane-replicated store data
package risac_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_FUNCT3,
    ERR_MISALIGN,
    ERR_RANGE
  } err_t;

  // Legality of a request; i_hi_nz flags any address bit above the RAM window.
  function automatic err_t lsu_classify(input logic       i_we,
                                        input logic [2:0] i_f3,
                                        input logic [1:0] i_lo,
                                        input logic       i_hi_nz);
    err_t r_cls;
    logic r_f3_ok;
    case (i_f3)
      F3_B, F3_H, F3_W: r_f3_ok = 1'b1;
      F3_BU, F3_HU:     r_f3_ok = ~i_we;  // unsigned variants exist only for loads
      default:          r_f3_ok = 1'b0;
    endcase
    if (!r_f3_ok)                                      r_cls = ERR_FUNCT3;
    else if ((i_f3[1:0] == 2'b01) && i_lo[0])          r_cls = ERR_MISALIGN;
    else if ((i_f3[1:0] == 2'b10) && (i_lo != 2'b00))  r_cls = ERR_MISALIGN;
    else if (i_hi_nz)                                  r_cls = ERR_RANGE;
    else                                               r_cls = ERR_NONE;
    return r_cls;
  endfunction

  // i_sz is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] lsu_be(input logic [1:0] i_sz, input logic [1:0] i_lo);
    case (i_sz)
      2'b00:   return 4'b0001 << i_lo;
      2'b01:   return 4'b0011 << i_lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; byteenable picks the live lane.
  function automatic logic [31:0] lsu_wdata(input logic [1:0] i_sz, input logic [31:0] i_wd);
    case (i_sz)
      2'b00:   return {4{i_wd[7:0]}};
      2'b01:   return {2{i_wd[15:0]}};
      default: return i_wd;
    endcase
  endfunction

endpackage

// File: rtl/risac_lsu_if.sv
// Interfaces of the risac load/store unit.
//   risac_lsu_req_if : core <-> LSU request/response handshake
//                      master = core, slave = LSU
//   risac_avm_if     : LSU <-> on-chip RAM (word address, byteenable, chipselect)
//                      master = LSU, slave = RAM
interface risac_lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_error);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_error);
endinterface

interface risac_avm_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-3:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
                  input  avm_readdata);
  modport slave  (input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
                  output avm_readdata);
endinterface

// File: rtl/risac_load_align.sv
// risac_load_align: combinational load-data alignment.
//   i_rdata  : raw 32-bit RAM word
//   i_lo     : byte offset addr[1:0]
//   i_funct3 : load funct3 (B/H sign-extend, BU/HU/W zero-extend)
//   o_rdata  : addressed byte/half moved to bit 0 and extended
module risac_load_align
  import risac_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_rdata >> {i_lo, 3'b000};

  always_comb begin
    o_rdata = w_shift;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_rdata = {24'h0, w_shift[7:0]};
      F3_HU:   o_rdata = {16'h0, w_shift[15:0]};
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/risac_lsu.sv
// risac_lsu: RV32I load/store unit between the core memory stage and the
// single-port on-chip RAM. One request in flight; illegal requests are
// answered with resp_error and never reach the bus.
//   clk, reset : clock, synchronous active-high reset
//   core       : request/response handshake (slave side)
//   avm        : RAM bus (master side), all outputs registered
module risac_lsu
  import risac_lsu_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  risac_lsu_req_if.slave  core,
  risac_avm_if.master     avm
);

  localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  state_t            r_state;
  logic              r_ready;
  logic [2:0]        r_funct3;
  logic [1:0]        r_lo;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cs;
  logic              r_write;
  logic [ADDR_W-3:0] r_address;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_resp_error;
  logic [31:0]       r_resp_rdata;

  err_t        w_err;
  logic        w_accept;
  logic [31:0] w_load_data;

  assign w_err    = lsu_classify(core.req_we, core.req_funct3, core.req_addr[1:0],
                                 |core.req_addr[31:ADDR_W]);
  assign w_accept = r_ready & core.req_valid;

  risac_load_align u_align (
    .i_rdata  (avm.avm_readdata),
    .i_lo     (r_lo),
    .i_funct3 (r_funct3),
    .o_rdata  (w_load_data)
  );

  // r_ready mirrors "state is IDLE" but is held low during reset so that
  // every output reads 0 while reset is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_funct3     <= 3'b000;
      r_lo         <= 2'b00;
      r_cnt        <= '0;
      r_cs         <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_be         <= 4'b0000;
      r_wdata      <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready  <= 1'b0;
            r_funct3 <= core.req_funct3;
            r_lo     <= core.req_addr[1:0];
            if (w_err != ERR_NONE) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else begin
              r_state   <= S_ACCESS;
              r_cs      <= 1'b1;
              r_write   <= core.req_we;
              r_address <= core.req_addr[ADDR_W-1:2];
              r_be      <= lsu_be(core.req_funct3[1:0], core.req_addr[1:0]);
              r_wdata   <= lsu_wdata(core.req_funct3[1:0], core.req_wdata);
            end
          end
        end
        S_ACCESS: begin
          r_cs      <= 1'b0;
          r_write   <= 1'b0;
          r_address <= '0;
          r_be      <= 4'b0000;
          r_wdata   <= 32'h0;
          if (r_write) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'h0;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(READ_LATENCY);
          end
        end
        S_WAIT: begin
          // The count reaching zero on this edge is the cycle readdata is valid.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_error <= 1'b0;
            r_resp_rdata <= w_load_data;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_error <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign core.req_ready      = r_ready;
  assign core.resp_valid     = r_resp_valid;
  assign core.resp_error     = r_resp_error;
  assign core.resp_rdata     = r_resp_rdata;
  assign avm.avm_chipselect  = r_cs;
  assign avm.avm_write       = r_write;
  assign avm.avm_address     = r_address;
  assign avm.avm_byteenable  = r_be;
  assign avm.avm_writedata   = r_wdata;

endmodule

// File: doc/risac_lsu.md
# risac_lsu

Load/store unit between the risac core's memory stage and the 32-bit single-port on-chip RAM slave (10-bit word address, byteenable, 1-cycle read latency). Accepts one RV32I load/store at a time, converts byte addresses and LB/LH/LW/LBU/LHU/SB/SH/SW into word address, byteenable and lane-replicated write data, and returns aligned, extended load data. Misaligned, out-of-range and illegal requests are rejected with an error response and never reach the bus.

## Interface
- ADDR_W, 12, byte-address width of the RAM window; word address is ADDR_W-2 bits (10)
- READ_LATENCY, 1, cycles from the bus read strobe to valid avm_readdata (≥1)
- clk  in  1  sole clock; all state on its rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle pulse; response complete
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_error  out  1  misaligned/out-of-range/illegal funct3
- avm_address  out  ADDR_W-2  word address
- avm_byteenable  out  4  lane enables
- avm_chipselect  out  1  bus access strobe
- avm_write  out  1  write strobe (qualified by chipselect)
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  RAM read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Reset → IDLE; all outputs 0.
- IDLE: req_ready=1. On req_valid, latch request; classify:
  - error if funct3 ∉ {000,001,010,100,101} (loads) or ∉ {000,001,010} (stores); H/HU with addr[0]=1; W with addr[1:0]≠0; any of addr[31:ADDR_W]≠0. Error → RESP with resp_error=1, rdata=0; no bus strobe.
  - else → ACCESS.
- ACCESS (one cycle): chipselect=1, address=addr[ADDR_W-1:2], write=req_we. Byteenable: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111 (same for loads). Writedata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata. Store → RESP; load → WAIT.
- WAIT: counter loaded with READ_LATENCY; decrement each cycle, bus strobes 0; on reaching 0 sample avm_readdata, shift right by 8*addr[1:0], sign-extend (B/H) or zero-extend (BU/HU/W) into resp_rdata → RESP.
- RESP: resp_valid=1 one cycle, resp_rdata/resp_error valid; → IDLE. No backpressure: core must take it.
- Bus outputs registered; chipselect/write never high outside ACCESS.
- Reset mid-operation: state → IDLE next edge; a strobe already driven in the reset cycle completes at the RAM; no resp_valid is produced for the aborted request.

## Timing
- Request accepted at edge E (cycle N). Error: resp_valid cycle N+1. Store: strobe N+1, resp_valid N+2. Load: strobe N+1, data sampled end of N+1+READ_LATENCY, resp_valid N+2+READ_LATENCY (N+3 default).
- Next request accepted earliest the cycle after resp_valid. Throughput: load 1 per 4 cycles, store 1 per 3 (default).
- req_valid while req_ready=0 ignored; core holds it.

## Structure
- Package risac_lsu_pkg: funct3 constants, state enum, byteenable function, error-class constants.
- Sub-module risac_load_align: combinational lane shift + sign/zero extension (readdata, addr[1:0], funct3 → rdata).

## Test plan
- SW addr 0x010, wdata 0xDEADBEEF → ACCESS: address 4, be 1111, write=1; resp_valid two cycles after accept, error 0.
- SB addr 0x013, wdata 0x000000A5 → be 1000, writedata 0xA5A5A5A5; subsequent LB 0x013 → rdata 0xFFFFFFA5, LBU → 0x000000A5.
- SH 0x022 wdata 0x8001, then LH 0x022 → 0xFFFF8001, LHU → 0x00008001, LW 0x020 → 0x8001xxxx upper lanes.
- LW 0x002, LH 0x001, LB 0x1000, funct3 011 → each resp_error=1 one cycle after accept, chipselect never asserted.
- Back-to-back req_valid held high for LW,SW,LW → accepts spaced per latency; req_ready low in ACCESS/WAIT/RESP.
- Reset asserted in WAIT of a load → IDLE next cycle, no resp_valid, all outputs 0; next request serviced normally.
